// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, mul/div opcodes and the mul/div sequencer states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2
    } muldiv_state_t;

    function automatic logic md_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply, or restoring shift-subtract divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] x_o
);

    logic [WIDTH:0] sum_c;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] shifted_c;
    logic [WIDTH:0] diff_c;
`else
    logic unused_div;
    assign unused_div = div_i;
`endif

    always_comb begin
        // {acc, x} holds the partial product; the multiplier bit retires from x[0]
        sum_c = {1'b0, acc_i} + (x_i[0] ? {1'b0, m_i} : '0);
        acc_o = sum_c[WIDTH:1];
        x_o   = {sum_c[0], x_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // acc is the partial remainder; quotient bits enter x from the right
        shifted_c = {acc_i, x_i[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, m_i};
        if (div_i) begin
            acc_o = diff_c[WIDTH] ? shifted_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
            x_o   = {x_i[WIDTH-2:0], ~diff_c[WIDTH]};
        end
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divides finish at once with divzero_o.
module muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  muldiv_op_t       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             divzero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;
`ifdef MULDIV_DIV_EN
    logic             rneg_q, rneg_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] adiv_q, adiv_d;
`endif

    logic             sgn_op_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [WIDTH-1:0] step_acc_c, step_x_c;
    logic [2*WIDTH-1:0] prod_c;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i (md_is_div(op_q)),
        .acc_i (acc_q),
        .x_i   (x_q),
        .m_i   (m_q),
        .acc_o (step_acc_c),
        .x_o   (step_x_c)
    );

    // Operand magnitudes; the iteration always runs unsigned
    always_comb begin
        sgn_op_c = md_is_signed(op_i);
        mag_a_c  = (sgn_op_c && a_i[WIDTH-1]) ? -a_i : a_i;
        mag_b_c  = (sgn_op_c && b_i[WIDTH-1]) ? -b_i : b_i;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        x_d       = x_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
`ifdef MULDIV_DIV_EN
        rneg_d    = rneg_q;
        bzero_d   = bzero_q;
        adiv_d    = adiv_q;
`endif
        prod_c = {acc_q, x_q};
        if (neg_q) begin
            prod_c = -prod_c;
        end

        case (state_q)
            MD_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d  = op_i;
                    cnt_d = '0;
                    acc_d = '0;
                    neg_d = sgn_op_c && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    if (md_is_div(op_i)) begin
                        x_d = mag_a_c;
                        m_d = mag_b_c;
`ifdef MULDIV_DIV_EN
                        rneg_d  = sgn_op_c && a_i[WIDTH-1];
                        bzero_d = (b_i == '0);
                        adiv_d  = a_i;
                        state_d = MD_CALC;
`else
                        state_d = MD_FIXUP;
`endif
                    end else begin
                        x_d     = mag_b_c;
                        m_d     = mag_a_c;
                        state_d = MD_CALC;
                    end
                end else begin
                    if (hi_we_i) hi_d = wdata_i;
                    if (lo_we_i) lo_d = wdata_i;
                end
            end
            MD_CALC: begin
                if (flush_i) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc_c;
                    x_d   = step_x_c;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = MD_FIXUP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MD_FIXUP: begin
                state_d = MD_IDLE;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (md_is_div(op_q)) begin
`ifdef MULDIV_DIV_EN
                        if (bzero_q) begin
                            lo_d      = '1;
                            hi_d      = adiv_q;
                            divzero_d = 1'b1;
                        end else begin
                            lo_d = neg_q  ? -x_q   : x_q;
                            hi_d = rneg_q ? -acc_q : acc_q;
                        end
`else
                        divzero_d = 1'b1;
`endif
                    end else begin
                        hi_d = prod_c[2*WIDTH-1:WIDTH];
                        lo_d = prod_c[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != MD_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_MULT;
            cnt_q     <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            rneg_q    <= 1'b0;
            bzero_q   <= 1'b0;
            adiv_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
`ifdef MULDIV_DIV_EN
            rneg_q    <= rneg_d;
            bzero_q   <= bzero_d;
            adiv_q    <= adiv_d;
`endif
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign divzero_o = divzero_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule
